// File: rtl/timer_pkg.sv
// Shared definitions for the countdown control slice: FSM state encodings and BCD limit.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_ALARM  = 3'd4
  } state_t;

  localparam int BCD_MAX = 9;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while run is low; clr forces it back to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_count;

  // The tick is seen by the controller in the same cycle the count sits at LAST.
  assign o_tick = i_run && (r_count == LAST);

  // Prescaler count: clear, wrap on tick, advance while running, otherwise hold.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Control stage ahead of the mod-10 ones down-counter: keypad digit load, count ticks,
// shadow remaining count and a timed alarm once the count reaches zero.
module countdown_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ALARM_TICKS = 5,
  parameter int DIGIT_W     = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [DIGIT_W-1:0] i_digit_in,
  input  logic               i_digit_valid,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_clear,
  input  logic               i_cnt_tc,
  output logic [DIGIT_W-1:0] o_load_data,
  output logic               o_loadn,
  output logic               o_cnt_enable,
  output logic               o_cnt_clrn,
  output logic [DIGIT_W-1:0] o_remain,
  output logic [2:0]         o_state,
  output logic               o_alarm
);

  localparam int                 AW         = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0]      ALARM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(BCD_MAX);

  state_t             r_state;
  logic [DIGIT_W-1:0] r_load_data;
  logic [DIGIT_W-1:0] r_remain;
  logic               r_loadn;
  logic               r_cnt_enable;
  logic               r_cnt_clrn;
  logic               r_alarm;
  logic [AW-1:0]      r_alarm_cnt;
  logic               r_rst_d;

  logic w_tick;
  logic w_digit_ok;
  logic w_tc_err;
  logic w_presc_run;
  logic w_presc_clr;

  assign w_digit_ok  = i_digit_valid && (i_digit_in <= DIGIT_MAX);
  assign w_tc_err    = i_cnt_tc && (r_remain != '0);
  assign w_presc_run = (r_state == ST_RUN) || (r_state == ST_ALARM);
  // Restart the prescaler whenever a new timing phase begins off a tick boundary.
  assign w_presc_clr = i_clear
                     || ((r_state == ST_LOADED) && !i_stop && i_start)
                     || ((r_state == ST_RUN) && w_tc_err)
                     || ((r_state == ST_ALARM) && (i_start || i_stop));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_run   (w_presc_run),
    .i_clr   (w_presc_clr),
    .o_tick  (w_tick)
  );

  // Controller FSM with shadow count, load/enable pulses, counter clear and alarm.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_load_data  <= '0;
      r_remain     <= '0;
      r_loadn      <= 1'b1;
      r_cnt_enable <= 1'b0;
      r_cnt_clrn   <= 1'b0;
      r_alarm      <= 1'b0;
      r_alarm_cnt  <= '0;
      r_rst_d      <= 1'b1;
    end else begin
      r_rst_d      <= 1'b0;
      r_loadn      <= 1'b1;
      r_cnt_enable <= 1'b0;
      // Counter clear stays asserted for one extra edge after reset release.
      r_cnt_clrn   <= !r_rst_d;
      if (i_clear) begin
        r_state     <= ST_IDLE;
        r_load_data <= '0;
        r_remain    <= '0;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
        r_cnt_clrn  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_digit_ok) begin
              r_load_data  <= i_digit_in;
              r_remain     <= i_digit_in;
              r_loadn      <= 1'b0;
              r_cnt_enable <= 1'b1;
              r_state      <= ST_LOADED;
            end
          end
          ST_LOADED: begin
            if (i_stop) begin
              r_state <= ST_LOADED;
            end else if (i_start) begin
              if (r_remain != '0) begin
                r_state <= ST_RUN;
              end else begin
                r_state     <= ST_ALARM;
                r_alarm     <= 1'b1;
                r_alarm_cnt <= '0;
              end
            end else if (w_digit_ok) begin
              r_load_data  <= i_digit_in;
              r_remain     <= i_digit_in;
              r_loadn      <= 1'b0;
              r_cnt_enable <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_tc_err) begin
              r_state     <= ST_ALARM;
              r_alarm     <= 1'b1;
              r_alarm_cnt <= '0;
              r_remain    <= '0;
            end else if (w_tick) begin
              r_cnt_enable <= 1'b1;
              r_remain     <= (r_remain != '0) ? r_remain - 1'b1 : '0;
              // Reaching zero outranks a coincident pause request.
              if (r_remain <= DIGIT_W'(1)) begin
                r_state     <= ST_ALARM;
                r_alarm     <= 1'b1;
                r_alarm_cnt <= '0;
              end else if (i_stop) begin
                r_state <= ST_PAUSE;
              end
            end else if (i_stop) begin
              r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (!i_stop && i_start) begin
              r_state <= ST_RUN;
            end
          end
          ST_ALARM: begin
            if (i_start || i_stop) begin
              r_state     <= ST_IDLE;
              r_alarm     <= 1'b0;
              r_alarm_cnt <= '0;
            end else if (w_tick) begin
              if (r_alarm_cnt == ALARM_LAST) begin
                r_state     <= ST_IDLE;
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
              end else begin
                r_alarm_cnt <= r_alarm_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_load_data  = r_load_data;
  assign o_loadn      = r_loadn;
  assign o_cnt_enable = r_cnt_enable;
  assign o_cnt_clrn   = r_cnt_clrn;
  assign o_remain     = r_remain;
  assign o_state      = r_state;
  assign o_alarm      = r_alarm;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed self-checking bench for countdown_ctrl with TICK_DIV=4, ALARM_TICKS=2.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       cnt_tc = 1'b0;
  logic [3:0] load_data;
  logic       loadn;
  logic       cnt_enable;
  logic       cnt_clrn;
  logic [3:0] remain;
  logic [2:0] state;
  logic       alarm;

  int checks = 0;
  int failures = 0;

  countdown_ctrl #(
    .TICK_DIV(4), .ALARM_TICKS(2), .DIGIT_W(4)
  ) dut (
    .i_clock(clk), .i_reset(reset), .i_digit_in(digit_in), .i_digit_valid(digit_valid),
    .i_start(start), .i_stop(stop), .i_clear(clear), .i_cnt_tc(cnt_tc),
    .o_load_data(load_data), .o_loadn(loadn), .o_cnt_enable(cnt_enable),
    .o_cnt_clrn(cnt_clrn), .o_remain(remain), .o_state(state), .o_alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1; cyc(); digit_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    checks++; if (state !== 3'd0 || loadn !== 1'b1 || cnt_enable !== 1'b0 || alarm !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got state=%0d loadn=%b en=%b alarm=%b exp 0/1/0/0", state, loadn, cnt_enable, alarm); end
    checks++; if (cnt_clrn !== 1'b0 || remain !== 4'd0 || load_data !== 4'd0) begin
      failures++; $display("FAIL reset_clrn got clrn=%b remain=%0d ld=%0d exp 0/0/0", cnt_clrn, remain, load_data); end
    reset = 1'b0; cyc();
    checks++; if (cnt_clrn !== 1'b0) begin failures++; $display("FAIL reset_clrn_hold got=%b exp=0", cnt_clrn); end
    cyc();
    checks++; if (cnt_clrn !== 1'b1) begin failures++; $display("FAIL reset_clrn_release got=%b exp=1", cnt_clrn); end
  endtask

  task automatic test_load();
    load_digit(4'd12);
    checks++; if (state !== 3'd0 || load_data !== 4'd0 || loadn !== 1'b1 || cnt_enable !== 1'b0) begin
      failures++; $display("FAIL load_invalid got state=%0d ld=%0d loadn=%b en=%b exp 0/0/1/0", state, load_data, loadn, cnt_enable); end
    load_digit(4'd7);
    checks++; if (state !== 3'd1 || load_data !== 4'd7 || remain !== 4'd7 || loadn !== 1'b0 || cnt_enable !== 1'b1) begin
      failures++; $display("FAIL load_seven got state=%0d ld=%0d rem=%0d loadn=%b en=%b exp 1/7/7/0/1", state, load_data, remain, loadn, cnt_enable); end
    cyc();
    checks++; if (state !== 3'd1 || loadn !== 1'b1 || cnt_enable !== 1'b0) begin
      failures++; $display("FAIL load_pulse_end got state=%0d loadn=%b en=%b exp 1/1/0", state, loadn, cnt_enable); end
  endtask

  task automatic test_countdown();
    load_digit(4'd3);
    checks++; if (load_data !== 4'd3 || remain !== 4'd3 || loadn !== 1'b0 || cnt_enable !== 1'b1) begin
      failures++; $display("FAIL count_reload got ld=%0d rem=%0d loadn=%b en=%b exp 3/3/0/1", load_data, remain, loadn, cnt_enable); end
    press_start();
    checks++; if (state !== 3'd2 || remain !== 4'd3 || cnt_enable !== 1'b0) begin
      failures++; $display("FAIL count_start got state=%0d rem=%0d en=%b exp 2/3/0", state, remain, cnt_enable); end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++; if (cnt_enable !== ((i % 4) == 0) || loadn !== 1'b1 || remain !== 4'(3 - i / 4)
                    || state !== ((i == 12) ? 3'd4 : 3'd2)) begin
        failures++; $display("FAIL count_cycle%0d got en=%b loadn=%b rem=%0d state=%0d exp en=%b rem=%0d", i,
                             cnt_enable, loadn, remain, state, (i % 4) == 0, 3 - i / 4); end
    end
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL count_alarm_on got=%b exp=1", alarm); end
    for (int j = 1; j <= 8; j++) begin
      cyc();
      checks++; if (alarm !== (j < 8) || state !== ((j < 8) ? 3'd4 : 3'd0) || cnt_enable !== 1'b0) begin
        failures++; $display("FAIL alarm_cycle%0d got alarm=%b state=%0d en=%b exp alarm=%b", j, alarm, state, cnt_enable, j < 8); end
    end
  endtask

  task automatic test_pause();
    int pulses;
    load_digit(4'd5); press_start();
    for (int i = 0; i < 4; i++) cyc();
    checks++; if (cnt_enable !== 1'b1 || remain !== 4'd4) begin
      failures++; $display("FAIL pause_first_tick got en=%b rem=%0d exp 1/4", cnt_enable, remain); end
    cyc(); stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (state !== 3'd3 || remain !== 4'd4) begin
      failures++; $display("FAIL pause_enter got state=%0d rem=%0d exp 3/4", state, remain); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cnt_enable === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || state !== 3'd3 || remain !== 4'd4) begin
      failures++; $display("FAIL pause_hold got pulses=%0d state=%0d rem=%0d exp 0/3/4", pulses, state, remain); end
    press_start();
    checks++; if (state !== 3'd2 || cnt_enable !== 1'b0) begin
      failures++; $display("FAIL pause_resume got state=%0d en=%b exp 2/0", state, cnt_enable); end
    cyc();
    checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL resume_early_tick got=%b exp=0", cnt_enable); end
    cyc();
    checks++; if (cnt_enable !== 1'b1 || remain !== 4'd3) begin
      failures++; $display("FAIL resume_tick got en=%b rem=%0d exp 1/3", cnt_enable, remain); end
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic test_clear_reset();
    cyc();
    load_digit(4'd6); press_start();
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (state !== 3'd2 || remain !== 4'd5) begin
      failures++; $display("FAIL clear_pre got state=%0d rem=%0d exp 2/5", state, remain); end
    clear = 1'b1; cyc(); clear = 1'b0;
    checks++; if (state !== 3'd0 || cnt_clrn !== 1'b0 || remain !== 4'd0 || load_data !== 4'd0 || alarm !== 1'b0) begin
      failures++; $display("FAIL clear_run got state=%0d clrn=%b rem=%0d ld=%0d alarm=%b exp 0/0/0/0/0", state, cnt_clrn, remain, load_data, alarm); end
    cyc();
    checks++; if (cnt_clrn !== 1'b1 || state !== 3'd0) begin
      failures++; $display("FAIL clear_clrn_one got clrn=%b state=%0d exp 1/0", cnt_clrn, state); end
    load_digit(4'd6); press_start();
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++; if (state !== 3'd0 || cnt_clrn !== 1'b0 || remain !== 4'd0 || load_data !== 4'd0) begin
      failures++; $display("FAIL reset_run got state=%0d clrn=%b rem=%0d ld=%0d exp 0/0/0/0", state, cnt_clrn, remain, load_data); end
    cyc();
    checks++; if (cnt_clrn !== 1'b0) begin failures++; $display("FAIL reset_run_clrn_hold got=%b exp=0", cnt_clrn); end
    cyc();
    checks++; if (cnt_clrn !== 1'b1) begin failures++; $display("FAIL reset_run_clrn_rel got=%b exp=1", cnt_clrn); end
  endtask

  task automatic test_corner();
    load_digit(4'd0);
    checks++; if (state !== 3'd1 || remain !== 4'd0) begin
      failures++; $display("FAIL zero_load got state=%0d rem=%0d exp 1/0", state, remain); end
    press_start();
    checks++; if (state !== 3'd4 || alarm !== 1'b1 || cnt_enable !== 1'b0) begin
      failures++; $display("FAIL zero_start got state=%0d alarm=%b en=%b exp 4/1/0", state, alarm, cnt_enable); end
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (state !== 3'd0 || alarm !== 1'b0) begin
      failures++; $display("FAIL alarm_stop got state=%0d alarm=%b exp 0/0", state, alarm); end
    load_digit(4'd5); press_start(); cyc(); cyc();
    cnt_tc = 1'b1; cyc(); cnt_tc = 1'b0;
    checks++; if (state !== 3'd4 || remain !== 4'd0 || alarm !== 1'b1 || cnt_enable !== 1'b0) begin
      failures++; $display("FAIL tc_mismatch got state=%0d rem=%0d alarm=%b en=%b exp 4/0/1/0", state, remain, alarm, cnt_enable); end
    press_start();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL alarm_start got state=%0d exp 0", state); end
    load_digit(4'd5); press_start(); cyc();
    start = 1'b1; stop = 1'b1; clear = 1'b1; cyc(); start = 1'b0; stop = 1'b0; clear = 1'b0;
    checks++; if (state !== 3'd0 || cnt_clrn !== 1'b0 || remain !== 4'd0) begin
      failures++; $display("FAIL clear_priority got state=%0d clrn=%b rem=%0d exp 0/0/0", state, cnt_clrn, remain); end
    digit_in = 4'd9; digit_valid = 1'b1; start = 1'b1; cyc(); digit_valid = 1'b0; start = 1'b0;
    checks++; if (state !== 3'd1 || load_data !== 4'd9) begin
      failures++; $display("FAIL load_nine got state=%0d ld=%0d exp 1/9", state, load_data); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_countdown();
    test_pause();
    test_clear_reset();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
